// File: rtl/rand_pkg.sv
// Shared types and defaults for the pseudo-random sources used by game logic.
package rand_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_e;

    // Known-good feedback masks for the common state widths
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h0000_0057;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            32'd8:   default_taps = {24'h00_0000, TAPS_W8};
            32'd16:  default_taps = {16'h0000, TAPS_W16};
            32'd32:  default_taps = TAPS_W32;
            default: default_taps = {16'h0000, TAPS_W16};
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with a loadable seed; an all-zero load is replaced by SEED
// because the zero state would lock the register.
module lfsr_core #(
    parameter int unsigned        LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  TAPS   = 16'h002D,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Load wins over step, step wins over hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            if (seed_in == '0) begin
                lfsr_d = SEED;
            end else begin
                lfsr_d = seed_in;
            end
        end else if (step) begin
            lfsr_d = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/random_lfsr.sv
// Pseudo-random source: free-running tap plus a req/valid draw bounded to
// [0, limit) by rejection sampling, with a zero fallback after MAX_TRIES rejects.
module random_lfsr
    import rand_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 16,
    parameter int unsigned       OUT_W     = 2,
    parameter logic [LFSR_W-1:0] TAPS      = 16'h002D,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int unsigned       MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    input  logic [OUT_W-1:0]  limit,
    output logic [OUT_W-1:0]  rand_out,
    output logic              valid,
    output logic              busy,
    output logic [OUT_W-1:0]  free_rand
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    state_e             state_q, state_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [OUT_W-1:0]   limit_q, limit_d;
    logic [OUT_W-1:0]   rand_q, rand_d;
    logic               valid_q, valid_d;
    logic               busy_q;
    logic [LFSR_W-1:0]  lfsr_s;
    logic [OUT_W-1:0]   cand_s;
    logic               step_s;

    assign step_s = ((state_q == IDLE) && en) || (state_q == DRAW);
    assign cand_s = lfsr_s[OUT_W-1:0];

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .step    (step_s),
        .load    (seed_load),
        .seed_in (seed_in),
        .q       (lfsr_s)
    );

    generate
        if (LFSR_W > OUT_W) begin : g_unused
            logic unused_hi_s;
            assign unused_hi_s = ^lfsr_s[LFSR_W-1:OUT_W];
        end
    endgenerate

    // Draw FSM: the candidate is the current register value, so each DRAW cycle tests one LFSR state
    always_comb begin
        state_d = state_q;
        try_d   = try_q;
        limit_d = limit_q;
        rand_d  = rand_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    limit_d = limit;
                    try_d   = '0;
                    state_d = DRAW;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAW: begin
                if ((limit_q == '0) || (cand_s < limit_q)) begin
                    rand_d  = cand_s;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (try_q == LAST_TRY) begin
                    rand_d  = '0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    try_d   = try_q + TRY_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            try_q   <= '0;
            limit_q <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            try_q   <= try_d;
            limit_q <= limit_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rand_out  = rand_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign free_rand = lfsr_s[OUT_W-1:0];

endmodule

// File: tb/tb_random_lfsr.sv
// Scoreboard bench for random_lfsr: expected draw results and latencies are
// computed from an independent LFSR model when each request is issued.
module tb_random_lfsr;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [1:0]  limit;
    logic [1:0]  rand_out;
    logic        valid;
    logic        busy;
    logic [1:0]  free_rand;

    typedef struct {
        logic [1:0] val;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    random_lfsr dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .limit     (limit),
        .rand_out  (rand_out),
        .valid     (valid),
        .busy      (busy),
        .free_rand (free_rand)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mstep(input logic [15:0] l);
        return {^(l & 16'h002D), l[15:1]};
    endfunction

    function automatic exp_t model_draw(input logic [15:0] seed, input logic [1:0] lim);
        logic [15:0] l;
        exp_t        e;
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int t = 0; t < 8; t++) begin
            if (lim == 2'd0 || l[1:0] < lim) begin
                e.val = l[1:0];
                e.lat = t + 2;
                return e;
            end
            l = mstep(l);
        end
        e.val = 2'd0;
        e.lat = 9;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load seed and request in the same cycle, then wait (bounded) for valid.
    task automatic draw(input string tag, input logic [15:0] seed, input logic [1:0] lim);
        int   waited;
        exp_t e;
        seed_load = 1'b1;
        seed_in   = seed;
        limit     = lim;
        req       = 1'b1;
        sb.push_back(model_draw(seed, lim));
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        limit     = ~lim;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        waited = 1;
        while (!valid && waited < 12) begin
            tick();
            waited++;
        end
        e = sb.pop_front();
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check({tag, " rand_out"}, {30'd0, rand_out}, {30'd0, e.val});
        check({tag, " latency"}, waited, e.lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst       = 1'b1;
        en        = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        req       = 1'b0;
        limit     = 2'd0;
        #12;
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst rand_out", {30'd0, rand_out}, 32'd0);
        check("rst free_rand", {30'd0, free_rand}, 32'd1);
        check("rst lfsr", {16'd0, dut.lfsr_s}, 32'h0000ACE1);
        rst = 1'b0;

        // Free-running steps
        en = 1'b1;
        tick();
        check("step1 lfsr", {16'd0, dut.lfsr_s}, 32'h00005670);
        check("step1 free_rand", {30'd0, free_rand}, 32'd0);
        tick();
        check("step2 lfsr", {16'd0, dut.lfsr_s}, 32'h0000AB38);
        check("step2 free_rand", {30'd0, free_rand}, 32'd0);
        en = 1'b0;
        tick();

        draw("min latency", 16'hACE1, 2'd3);
        draw("one reject", 16'h5673, 2'd3);
        draw("fallback", 16'hFFFF, 2'd1);
        draw("full range", 16'h1234, 2'd0);
        draw("limit2", 16'h5670, 2'd2);
        draw("zero seed", 16'h0000, 2'd2);
        for (int i = 0; i < 10; i++) begin
            draw("random", 16'($urandom), 2'($urandom_range(0, 3)));
        end
        tick();
        check("idle valid", {31'd0, valid}, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);

        // Zero seed load substitutes the default seed
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        seed_load = 1'b0;
        check("zero load lfsr", {16'd0, dut.lfsr_s}, 32'h0000ACE1);

        // Requests while busy are ignored
        seed_load = 1'b1;
        seed_in   = 16'hFFFF;
        limit     = 2'd1;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        limit     = 2'd3;
        for (int i = 0; i < 4; i++) tick();
        req    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) begin
                pulses++;
                check("busy req rand_out", {30'd0, rand_out}, 32'd0);
            end
            tick();
        end
        check("busy req pulses", pulses, 1);
        check("busy req busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a draw
        seed_load = 1'b1;
        seed_in   = 16'hFFFF;
        limit     = 2'd1;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        tick();
        tick();
        check("pre-rst busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst valid", {31'd0, valid}, 32'd0);
        check("async rst lfsr", {16'd0, dut.lfsr_s}, 32'h0000ACE1);
        tick();
        #3 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) pulses++;
        end
        check("post-rst pulses", pulses, 0);
        check("post-rst lfsr", {16'd0, dut.lfsr_s}, 32'h0000ACE1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
